idma_legalizer_req_arbiter: RTL and testbench

//   Round-robin scheduler sharing one legalizer 1D request port among NumReq front-ends.

---
 rtl/idma_legalizer_req_arbiter.sv | 136 +++++++++++++
 tb/tb_idma_legalizer_req_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_legalizer_req_arbiter.sv
// Round-robin arbiter sharing one legalizer 1D request port among NumReq front-ends.
// A grant is held until the legalizer accepts it. The owner is then queued in an
// in-order ownership FIFO, so that in-order completions and kills can be routed back.
module idma_legalizer_req_arbiter #(
   parameter int unsigned NumReq         = 4,
   parameter int unsigned MaxOutstanding = 8,
   parameter type         idma_req_t     = logic,
   parameter int unsigned IdxWidth       = $clog2(NumReq),
   parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  idma_req_t [NumReq-1:0]       req_i,
   input  logic      [NumReq-1:0]       req_valid_i,
   output logic      [NumReq-1:0]       req_ready_o,
   input  logic      [NumReq-1:0]       kill_req_i,
   output idma_req_t                    leg_req_o,
   output logic                         leg_valid_o,
   input  logic                         leg_ready_i,
   output logic                         leg_kill_o,
   input  logic                         cmpl_i,
   output logic      [NumReq-1:0]       done_o,
   output logic      [IdxWidth-1:0]     owner_o,
   output logic      [CntWidth-1:0]     outstanding_o,
   output logic                         busy_o,
   output logic                         cmpl_err_o
);

   localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 1);
   localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);
   localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);

   typedef enum logic {StArb, StOffer} state_e;

   state_e                state_q;
   logic [IdxWidth-1:0]   gnt_q, rr_ptr_q;
   logic [IdxWidth-1:0]   fifo_q [MaxOutstanding];
   logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntWidth-1:0]   cnt_q, cnt_after;
   logic                  cmpl_err_q;

   logic                  offer, empty, push, pop;
   logic [IdxWidth-1:0]   head, gnt_inc;
   logic [NumReq-1:0]     gnt_oh, arb_mask, rearb_mask;
   logic [IdxWidth:0]     arb_pick, rearb_pick;

   // First set bit of mask searching upward from start, with wrap-around; MSB = found.
   function automatic logic [IdxWidth:0] rr_pick(input logic [NumReq-1:0]   mask,
                                                 input logic [IdxWidth-1:0] start);
      logic                found;
      logic [IdxWidth-1:0] idx;
      int unsigned         pos;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         pos = (32'(start) + i) % NumReq;
         if (!found && mask[pos]) begin
            found = 1'b1;
            idx   = IdxWidth'(pos);
         end
      end
      return {found, idx};
   endfunction

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
      return (ptr == LastPtr) ? '0 : ptr + PtrWidth'(1);
   endfunction

   // Datapath routing, FIFO bookkeeping and both arbitration candidates.
   always_comb begin
      offer      = (state_q == StOffer);
      empty      = (cnt_q == '0);
      head       = fifo_q[rd_ptr_q];
      gnt_oh     = NumReq'(1) << gnt_q;
      gnt_inc    = (gnt_q == LastIdx) ? '0 : gnt_q + IdxWidth'(1);
      push       = offer & leg_ready_i;
      pop        = cmpl_i & ~empty;
      cnt_after  = cnt_q + CntWidth'(push) - CntWidth'(pop);
      // ARB uses the registered count: a slot freed by a pop is usable from the next edge.
      arb_mask   = req_valid_i & {NumReq{cnt_q < MaxCnt}};
      rearb_mask = req_valid_i & ~gnt_oh & {NumReq{cnt_after < MaxCnt}};
      arb_pick   = rr_pick(arb_mask, rr_ptr_q);
      rearb_pick = rr_pick(rearb_mask, gnt_inc);

      leg_valid_o   = offer;
      leg_req_o     = offer ? req_i[gnt_q] : '0;
      req_ready_o   = offer ? (gnt_oh & {NumReq{leg_ready_i}}) : '0;
      owner_o       = empty ? '0 : head;
      done_o        = pop ? (NumReq'(1) << head) : '0;
      leg_kill_o    = ~empty & kill_req_i[head];
      outstanding_o = cnt_q;
      busy_o        = offer | ~empty;
      cmpl_err_o    = cmpl_err_q;
   end

   // Grant FSM, round-robin pointer and ownership FIFO.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StArb;
         gnt_q      <= '0;
         rr_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         cmpl_err_q <= 1'b0;
         fifo_q     <= '{default: '0};
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= gnt_q;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_after;
         if (cmpl_i && empty) cmpl_err_q <= 1'b1;
         unique case (state_q)
            StArb: begin
               if (arb_pick[IdxWidth]) begin
                  gnt_q   <= arb_pick[IdxWidth-1:0];
                  state_q <= StOffer;
               end
            end
            StOffer: begin
               if (leg_ready_i) begin
                  rr_ptr_q <= gnt_inc;
                  // Back-to-back grant avoids a dead ARB cycle between transfers.
                  if (rearb_pick[IdxWidth]) gnt_q <= rearb_pick[IdxWidth-1:0];
                  else                      state_q <= StArb;
               end
            end
            default: state_q <= StArb;
         endcase
      end
   end

endmodule

// File: tb/tb_idma_legalizer_req_arbiter.sv
// Self-checking bench for idma_legalizer_req_arbiter (NumReq=4, MaxOutstanding=8).
module tb_idma_legalizer_req_arbiter;

   localparam int unsigned NumReq         = 4;
   localparam int unsigned MaxOutstanding = 8;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic [NumReq-1:0][31:0] req_i;
   logic [NumReq-1:0]      req_valid_i;
   logic [NumReq-1:0]      req_ready_o;
   logic [NumReq-1:0]      kill_req_i;
   logic [31:0]            leg_req_o;
   logic                   leg_valid_o;
   logic                   leg_ready_i;
   logic                   leg_kill_o;
   logic                   cmpl_i;
   logic [NumReq-1:0]      done_o;
   logic [1:0]             owner_o;
   logic [3:0]             outstanding_o;
   logic                   busy_o;
   logic                   cmpl_err_o;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];   // expected grant order
   int own_q[$];   // expected ownership FIFO contents

   idma_legalizer_req_arbiter #(
      .NumReq         (NumReq),
      .MaxOutstanding (MaxOutstanding),
      .idma_req_t     (logic [31:0])
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_i         (req_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .kill_req_i    (kill_req_i),
      .leg_req_o     (leg_req_o),
      .leg_valid_o   (leg_valid_o),
      .leg_ready_i   (leg_ready_i),
      .leg_kill_o    (leg_kill_o),
      .cmpl_i        (cmpl_i),
      .done_o        (done_o),
      .owner_o       (owner_o),
      .outstanding_o (outstanding_o),
      .busy_o        (busy_o),
      .cmpl_err_o    (cmpl_err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [NumReq-1:0] onehot(input int i);
      logic [NumReq-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic reset_dut();
      rst_i       = 1'b1;
      req_valid_i = '0;
      kill_req_i  = '0;
      leg_ready_i = 1'b0;
      cmpl_i      = 1'b0;
      for (int i = 0; i < NumReq; i++) req_i[i] = 32'h0;
      step();
      rst_i = 1'b0;
      exp_q.delete();
      own_q.delete();
   endtask

   task automatic test_reset();
      reset_dut();
      #1;
      n_checks++; if (leg_valid_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_leg_valid: got %b want 0", leg_valid_o); end
      n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++;
         $display("FAIL reset_req_ready: got %b want 0000", req_ready_o); end
      n_checks++; if (outstanding_o !== 4'd0) begin n_fail++;
         $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
      n_checks++; if ({busy_o, cmpl_err_o, owner_o, done_o} !== 8'h00) begin n_fail++;
         $display("FAIL reset_misc: got %h want 00", {busy_o, cmpl_err_o, owner_o, done_o}); end
   endtask

   task automatic test_single();
      reset_dut();
      req_i[2]    = 32'hC0DE_0002;
      req_valid_i = 4'b0100;
      leg_ready_i = 1'b1;
      #1;
      n_checks++; if (leg_valid_o !== 1'b0) begin n_fail++;
         $display("FAIL single_arb_cycle: got leg_valid %b want 0", leg_valid_o); end
      step(); #1;
      n_checks++; if (leg_valid_o !== 1'b1 || req_ready_o !== 4'b0100) begin n_fail++;
         $display("FAIL single_offer: got valid %b ready %b want 1 0100",
                  leg_valid_o, req_ready_o); end
      n_checks++; if (leg_req_o !== 32'hC0DE_0002) begin n_fail++;
         $display("FAIL single_req: got %h want c0de0002", leg_req_o); end
      step();
      req_valid_i = '0;
      #1;
      n_checks++; if (outstanding_o !== 4'd1 || owner_o !== 2'd2 || leg_valid_o !== 1'b0)
      begin n_fail++;
         $display("FAIL single_queued: got out %0d owner %0d valid %b want 1 2 0",
                  outstanding_o, owner_o, leg_valid_o); end
      cmpl_i = 1'b1;
      #1;
      n_checks++; if (done_o !== 4'b0100) begin n_fail++;
         $display("FAIL single_done: got %b want 0100", done_o); end
      step();
      cmpl_i = 1'b0;
      #1;
      n_checks++; if (outstanding_o !== 4'd0 || busy_o !== 1'b0) begin n_fail++;
         $display("FAIL single_drained: got out %0d busy %b want 0 0", outstanding_o, busy_o); end
   endtask

   // Round robin back-to-back, then fill to MaxOutstanding and drain in order.
   task automatic test_back_to_back();
      int cyc;
      int e;
      int w;
      reset_dut();
      for (int i = 0; i < NumReq; i++) req_i[i] = 32'hA000_0000 + i;
      for (int k = 0; k < 8; k++) exp_q.push_back(k % NumReq);
      req_valid_i = 4'b1111;
      leg_ready_i = 1'b1;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 40) begin
         #1;
         if (leg_valid_o === 1'b1) begin
            e = exp_q.pop_front();
            own_q.push_back(e);
            n_checks++; if (req_ready_o !== onehot(e) || leg_req_o !== req_i[e]) begin n_fail++;
               $display("FAIL rr_grant: got ready %b req %h want %b %h",
                        req_ready_o, leg_req_o, onehot(e), req_i[e]); end
         end
         step();
         cyc++;
      end
      n_checks++; if (cyc != 9) begin n_fail++;
         $display("FAIL rr_cycles: got %0d cycles want 9", cyc); end
      #1;
      n_checks++; if (outstanding_o !== 4'd8 || leg_valid_o !== 1'b0 || req_ready_o !== '0)
      begin n_fail++;
         $display("FAIL full_block: got out %0d valid %b ready %b want 8 0 0000",
                  outstanding_o, leg_valid_o, req_ready_o); end
      step(); #1;
      n_checks++; if (leg_valid_o !== 1'b0) begin n_fail++;
         $display("FAIL full_hold: got valid %b want 0", leg_valid_o); end
      cmpl_i = 1'b1;
      #1;
      e = own_q.pop_front();
      n_checks++; if (done_o !== onehot(e)) begin n_fail++;
         $display("FAIL full_done: got %b want %b", done_o, onehot(e)); end
      step();
      cmpl_i = 1'b0;
      #1;
      n_checks++; if (outstanding_o !== 4'd7) begin n_fail++;
         $display("FAIL full_pop: got %0d want 7", outstanding_o); end
      w = 0;
      while (leg_valid_o !== 1'b1 && w < 2) begin
         step(); #1;
         w++;
      end
      n_checks++; if (leg_valid_o !== 1'b1 || req_ready_o !== 4'b0001) begin n_fail++;
         $display("FAIL refill_offer: got valid %b ready %b want 1 0001",
                  leg_valid_o, req_ready_o); end
      own_q.push_back(0);
      step();
      req_valid_i = '0;
      #1;
      n_checks++; if (outstanding_o !== 4'd8) begin n_fail++;
         $display("FAIL refill_count: got %0d want 8", outstanding_o); end
      while (own_q.size() > 0) begin
         cmpl_i = 1'b1;
         #1;
         e = own_q.pop_front();
         n_checks++; if (done_o !== onehot(e)) begin n_fail++;
            $display("FAIL drain_done: got %b want %b", done_o, onehot(e)); end
         step();
      end
      cmpl_i = 1'b0;
      #1;
      n_checks++; if (outstanding_o !== 4'd0) begin n_fail++;
         $display("FAIL drain_empty: got %0d want 0", outstanding_o); end
   endtask

   task automatic test_stall();
      int e;
      reset_dut();
      req_i[1]    = 32'h1111_0001;
      req_i[3]    = 32'h3333_0003;
      req_valid_i = 4'b0010;
      step();
      req_valid_i = 4'b1010;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (leg_valid_o !== 1'b1 || leg_req_o !== 32'h1111_0001 ||
                         req_ready_o !== 4'b0000) begin n_fail++;
            $display("FAIL stall_hold: got valid %b req %h ready %b want 1 11110001 0000",
                     leg_valid_o, leg_req_o, req_ready_o); end
         step();
      end
      leg_ready_i = 1'b1;
      #1;
      n_checks++; if (req_ready_o !== 4'b0010) begin n_fail++;
         $display("FAIL stall_release: got %b want 0010", req_ready_o); end
      own_q.push_back(1);
      step();
      req_valid_i = 4'b1000;
      #1;
      n_checks++; if (req_ready_o !== 4'b1000 || leg_req_o !== 32'h3333_0003) begin n_fail++;
         $display("FAIL stall_next: got ready %b req %h want 1000 33330003",
                  req_ready_o, leg_req_o); end
      own_q.push_back(3);
      step();
      req_valid_i = '0;
      leg_ready_i = 1'b0;
      #1;
      n_checks++; if (outstanding_o !== 4'd2 || owner_o !== 2'd1) begin n_fail++;
         $display("FAIL stall_fifo: got out %0d owner %0d want 2 1", outstanding_o, owner_o); end
      while (own_q.size() > 0) begin
         cmpl_i = 1'b1;
         #1;
         e = own_q.pop_front();
         n_checks++; if (done_o !== onehot(e)) begin n_fail++;
            $display("FAIL stall_done: got %b want %b", done_o, onehot(e)); end
         step();
      end
      cmpl_i = 1'b0;
   endtask

   task automatic test_kill();
      reset_dut();
      kill_req_i = 4'b0001;
      #1;
      n_checks++; if (leg_kill_o !== 1'b0) begin n_fail++;
         $display("FAIL kill_empty: got %b want 0", leg_kill_o); end
      kill_req_i  = '0;
      req_valid_i = 4'b0100;
      leg_ready_i = 1'b1;
      step();
      step();
      req_valid_i = '0;
      leg_ready_i = 1'b0;
      kill_req_i  = 4'b0010;
      #1;
      n_checks++; if (leg_kill_o !== 1'b0 || owner_o !== 2'd2) begin n_fail++;
         $display("FAIL kill_other: got kill %b owner %0d want 0 2", leg_kill_o, owner_o); end
      kill_req_i = 4'b0100;
      #1;
      n_checks++; if (leg_kill_o !== 1'b1) begin n_fail++;
         $display("FAIL kill_owner: got %b want 1", leg_kill_o); end
      step();
      kill_req_i = '0;
      #1;
      n_checks++; if (outstanding_o !== 4'd1 || leg_kill_o !== 1'b0) begin n_fail++;
         $display("FAIL kill_keeps_slot: got out %0d kill %b want 1 0",
                  outstanding_o, leg_kill_o); end
      cmpl_i = 1'b1;
      #1;
      n_checks++; if (done_o !== 4'b0100) begin n_fail++;
         $display("FAIL kill_done: got %b want 0100", done_o); end
      step();
      cmpl_i = 1'b0;
   endtask

   task automatic test_cmpl_err_and_reset();
      reset_dut();
      cmpl_i = 1'b1;
      #1;
      n_checks++; if (done_o !== 4'b0000) begin n_fail++;
         $display("FAIL err_no_done: got %b want 0000", done_o); end
      step();
      cmpl_i = 1'b0;
      #1;
      n_checks++; if (cmpl_err_o !== 1'b1 || outstanding_o !== 4'd0) begin n_fail++;
         $display("FAIL err_set: got err %b out %0d want 1 0", cmpl_err_o, outstanding_o); end
      step(); #1;
      n_checks++; if (cmpl_err_o !== 1'b1) begin n_fail++;
         $display("FAIL err_sticky: got %b want 1", cmpl_err_o); end
      req_valid_i = 4'b0001;
      step(); #1;
      n_checks++; if (leg_valid_o !== 1'b1) begin n_fail++;
         $display("FAIL err_offer: got %b want 1", leg_valid_o); end
      rst_i = 1'b1;
      step();
      rst_i       = 1'b0;
      req_valid_i = '0;
      #1;
      n_checks++; if (leg_valid_o !== 1'b0 || outstanding_o !== 4'd0 || cmpl_err_o !== 1'b0 ||
                      busy_o !== 1'b0) begin n_fail++;
         $display("FAIL mid_offer_reset: got valid %b out %0d err %b busy %b want 0 0 0 0",
                  leg_valid_o, outstanding_o, cmpl_err_o, busy_o); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_kill();
      test_cmpl_err_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
